// File: rtl/nios_ii_system_key_pkg.sv
// Shared definitions for the key scheduler: register map, event entry
// width and field positions inside the 32-bit readdata word.
package nios_ii_system_key_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_LEVELS = 2'd0;
    localparam logic [1:0] ADDR_EVENT  = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_OVF    = 2'd3;

    // One FIFO entry holds a key index; the event register exposes it in
    // bits [1:0], which limits the scheduler to four keys.
    localparam int ENTRY_W = 2;

    // Field positions in the event status word
    localparam int RD_VALID_BIT = 31;
    localparam int RD_OCC_MSB   = 7;
    localparam int RD_OCC_LSB   = 4;
    localparam int RD_HEAD_MSB  = 1;
    localparam int RD_HEAD_LSB  = 0;

    typedef logic [ENTRY_W-1:0] key_idx_t;

    // Build the event status word; an empty queue reads as all zeros.
    function automatic logic [31:0] pack_event_status(
        input logic       not_empty,
        input logic [3:0] occupancy,
        input key_idx_t   head
    );
        logic [31:0] word;
        word = 32'h0000_0000;
        if (not_empty) begin
            word[RD_VALID_BIT]             = 1'b1;
            word[RD_OCC_MSB:RD_OCC_LSB]    = occupancy;
            word[RD_HEAD_MSB:RD_HEAD_LSB]  = head;
        end else begin
            word = 32'h0000_0000;
        end
        return word;
    endfunction

endpackage

// File: rtl/nios_ii_system_key_debouncer.sv
// Per-key front end: two-flop synchronizer, stable-level debounce counter
// and a one-cycle press pulse on a debounced 1->0 transition.
module nios_ii_system_key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic stable_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // Synchronize the raw key, then accept a new level only after it has
    // differed from the stable level for DEBOUNCE_CYCLES sampled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= {CNT_W{1'b0}};
            press_q  <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= {CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= {CNT_W{1'b0}};
                // Mismatch while stable is 1 means the key has gone to 0.
                press_q  <= stable_q;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/nios_ii_system_key_scheduler.sv
// Key scheduler: debounced key presses become pending requests, a
// round-robin arbiter moves one per cycle into an event FIFO, and an
// Avalon slave exposes levels, events, the irq mask and overflow flags.
module nios_ii_system_key_scheduler
    import nios_ii_system_key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                read_n,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    input  logic [NUM_KEYS-1:0] in_port,
    output logic [31:0]         readdata,
    output logic                irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam key_idx_t         KEY_LAST = key_idx_t'(NUM_KEYS - 1);
    localparam key_idx_t         KEY_ONE  = key_idx_t'(1);

    // Debounced per-key state
    logic [NUM_KEYS-1:0] stable_s;
    logic [NUM_KEYS-1:0] press_s;

    // Request / arbitration state
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [NUM_KEYS-1:0] overflow_q, overflow_d;
    key_idx_t            rr_ptr_q, rr_ptr_d;
    logic                grant_valid_s;
    key_idx_t            grant_idx_s;
    logic [NUM_KEYS-1:0] grant_mask_s;
    logic [NUM_KEYS-1:0] ovf_new_s;

    // Event FIFO
    key_idx_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic                push_s;
    logic                pop_s;
    key_idx_t            head_s;

    // Bus side
    logic                rd_strobe_s;
    logic                wr_strobe_s;
    logic                irq_mask_q, irq_mask_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                unused_wdata_s;

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            nios_ii_system_key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk      (clk),
                .reset_n  (reset_n),
                .key_n_i  (in_port[k]),
                .stable_o (stable_s[k]),
                .press_o  (press_s[k])
            );
        end
    endgenerate

    assign rd_strobe_s    = chipselect & ~read_n;
    assign wr_strobe_s    = chipselect & ~write_n;
    // Full/empty come from registered occupancy only, so a pop in the same
    // cycle never opens a slot for a push while the queue is full.
    assign fifo_empty_s   = (occ_q == {OCC_W{1'b0}});
    assign fifo_full_s    = (occ_q == OCC_FULL);
    assign pop_s          = rd_strobe_s && (address == ADDR_EVENT) && !fifo_empty_s;
    assign push_s         = grant_valid_s;
    assign head_s         = mem_q[rd_ptr_q];
    assign unused_wdata_s = ^writedata[31:1];

    // Round-robin search over pending keys starting at rr_ptr; no grant when full.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {ENTRY_W{1'b0}};
        grant_mask_s  = {NUM_KEYS{1'b0}};
        if (!fifo_full_s) begin
            for (int off = 0; off < NUM_KEYS; off++) begin
                if (!grant_valid_s && pending_q[(int'(rr_ptr_q) + off) % NUM_KEYS]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = key_idx_t'((int'(rr_ptr_q) + off) % NUM_KEYS);
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end else begin
            grant_valid_s = 1'b0;
        end
        if (grant_valid_s) begin
            grant_mask_s = {{(NUM_KEYS-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            grant_mask_s = {NUM_KEYS{1'b0}};
        end
    end

    // Next-state for pending, overflow and the round-robin pointer.
    always_comb begin
        // A new press for a key being granted this cycle keeps it pending
        // and is not a lost event, so it does not count as overflow.
        ovf_new_s = press_s & pending_q & ~grant_mask_s;
        pending_d = (pending_q & ~grant_mask_s) | press_s;
        if (wr_strobe_s && (address == ADDR_OVF)) begin
            overflow_d = ovf_new_s;
        end else begin
            overflow_d = overflow_q | ovf_new_s;
        end
        if (grant_valid_s) begin
            rr_ptr_d = (grant_idx_s == KEY_LAST) ? {ENTRY_W{1'b0}} : grant_idx_s + KEY_ONE;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (wr_strobe_s && (address == ADDR_MASK)) begin
            irq_mask_d = writedata[0];
        end else begin
            irq_mask_d = irq_mask_q;
        end
    end

    // Read mux: the word for the addressed register, captured one cycle later.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_strobe_s) begin
            case (address)
                ADDR_LEVELS: begin
                    readdata_d = 32'h0000_0000;
                    readdata_d[NUM_KEYS-1:0] = stable_s;
                end
                ADDR_EVENT: readdata_d = pack_event_status(!fifo_empty_s, 4'(occ_q), head_s);
                ADDR_MASK: readdata_d = {31'h0000_0000, irq_mask_q};
                ADDR_OVF: begin
                    readdata_d = 32'h0000_0000;
                    readdata_d[NUM_KEYS-1:0] = overflow_q;
                end
                default: readdata_d = 32'h0000_0000;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Control and bus registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= {NUM_KEYS{1'b0}};
            overflow_q <= {NUM_KEYS{1'b0}};
            rr_ptr_q   <= {ENTRY_W{1'b0}};
            irq_mask_q <= 1'b0;
            readdata_q <= 32'h0000_0000;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            rr_ptr_q   <= rr_ptr_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            occ_q    <= {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= grant_idx_s;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_q <= occ_q + OCC_ONE;
                2'b01:   occ_q <= occ_q - OCC_ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_mask_q & ~fifo_empty_s;

endmodule

// File: tb/tb_nios_ii_system_key_scheduler.sv
// Self-checking bench for the key scheduler with a short debounce window.
// Expected FIFO contents are kept in a scoreboard queue filled as presses
// are driven and drained as event reads are compared.
module tb_nios_ii_system_key_scheduler;

    localparam int NUM_KEYS = 4;
    localparam int DEB      = 8;
    localparam int DEPTH    = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  exp_q[$];
    logic [31:0] rd;

    nios_ii_system_key_scheduler #(
        .NUM_KEYS        (NUM_KEYS),
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] data);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        data = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = data;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    // Hold the keys in mask pressed for n cycles, then release and settle.
    task automatic press(input logic [3:0] mask, input int n);
        @(negedge clk);
        in_port = ~mask;
        tick(n);
        in_port = 4'hF;
        tick(14);
    endtask

    // Read the event register and compare against the scoreboard head.
    task automatic read_event(input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        if (exp_q.size() == 0) begin
            exp = 32'h0000_0000;
        end else begin
            exp = 32'h8000_0000 | (32'(exp_q.size()) << 4) | 32'(exp_q[0]);
            void'(exp_q.pop_front());
        end
        bus_read(2'd1, got);
        check_eq(tag, got, exp);
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = 32'h0; in_port = 4'hF;
        tick(3);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        check_eq("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        tick(2);
        bus_read(2'd0, rd); check_eq("rst_levels", rd, 32'h0000_000F);
        read_event("rst_event_empty");
        bus_read(2'd2, rd); check_eq("rst_mask", rd, 32'h0);
        bus_read(2'd3, rd); check_eq("rst_ovf", rd, 32'h0);

        // Short glitch on key 1: too short to be accepted.
        press(4'b0010, DEB - 1);
        read_event("short_press_no_event");

        // Long press on key 1: level visible while held, one event queued.
        @(negedge clk);
        in_port = 4'b1101;
        tick(12);
        bus_read(2'd0, rd); check_eq("held_levels", rd, 32'h0000_000D);
        in_port = 4'hF;
        tick(14);
        exp_q.push_back(2'd1);
        check_eq("irq_masked", {31'h0, irq}, 32'h0);
        bus_write(2'd2, 32'h1);
        check_eq("irq_unmasked", {31'h0, irq}, 32'h1);
        bus_read(2'd2, rd); check_eq("mask_readback", rd, 32'h1);
        bus_read(2'd0, rd); check_eq("released_levels", rd, 32'h0000_000F);
        read_event("key1_event");
        check_eq("irq_after_drain", {31'h0, irq}, 32'h0);

        // Key 0 alone moves the round-robin pointer to 1.
        press(4'b0001, 12);
        exp_q.push_back(2'd0);
        read_event("key0_event");

        // Keys 0, 2, 3 together with rr_ptr=1: order 2, 3, 0.
        press(4'b1101, 12);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        read_event("rr_first");
        read_event("rr_second");
        read_event("rr_third");

        // Fill the FIFO, then press key 0 twice while full.
        press(4'b0010, 12); exp_q.push_back(2'd1);
        press(4'b0100, 12); exp_q.push_back(2'd2);
        press(4'b1000, 12); exp_q.push_back(2'd3);
        press(4'b0010, 12); exp_q.push_back(2'd1);
        check_eq("irq_full", {31'h0, irq}, 32'h1);
        press(4'b0001, 12);
        bus_read(2'd3, rd); check_eq("ovf_after_one", rd, 32'h0);
        press(4'b0001, 12);
        bus_read(2'd3, rd); check_eq("ovf_after_two", rd, 32'h1);
        read_event("full_pop");
        exp_q.push_back(2'd0);
        tick(3);
        read_event("refill_after_pop");
        read_event("drain_a");
        read_event("drain_b");
        read_event("drain_c");
        read_event("empty_read_1");
        read_event("empty_read_2");
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd); check_eq("ovf_cleared", rd, 32'h0);

        // Reset with three entries queued and a debounce in progress.
        press(4'b0010, 12); exp_q.push_back(2'd1);
        press(4'b0100, 12); exp_q.push_back(2'd2);
        press(4'b1000, 12); exp_q.push_back(2'd3);
        check_eq("irq_before_reset", {31'h0, irq}, 32'h1);
        bus_read(2'd2, rd); check_eq("mask_before_reset", rd, 32'h1);
        in_port = 4'b1110;
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_irq", {31'h0, irq}, 32'h0);
        check_eq("async_rst_readdata", readdata, 32'h0);
        in_port = 4'hF;
        tick(3);
        reset_n = 1'b1;
        exp_q.delete();
        tick(20);
        check_eq("post_rst_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd0, rd); check_eq("post_rst_levels", rd, 32'h0000_000F);
        read_event("post_rst_event");
        bus_read(2'd2, rd); check_eq("post_rst_mask", rd, 32'h0);
        bus_read(2'd3, rd); check_eq("post_rst_ovf", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_ii_system_key_scheduler.md
NIOS_II_SYSTEM_KEY_SCHEDULER -- requirements
Module: nios_ii_system_key_scheduler

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of active-low key inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles required to accept a level change.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, event queue entries (power of two).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port address, input, 2, Avalon slave word address.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have ports read_n and write_n, inputs, 1 each, active-low strobes.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port in_port, input, NUM_KEYS, raw asynchronous key levels (0 = pressed).
REQ-011 SHALL have port readdata, output, 32, registered read data.
REQ-012 SHALL have port irq, output, 1, interrupt request.

Function
REQ-013 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL hold a per-key stable level, and a per-key counter that clears whenever the synchronized level equals the stable level.
REQ-015 SHALL update the stable level when the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present; the counter then clears.
REQ-016 SHALL raise a press event for key i when its stable level goes 1->0; releases SHALL NOT raise events.
REQ-017 SHALL set pending[i] on a press event; if pending[i] is already set, SHALL instead set sticky overflow[i].
REQ-018 SHALL grant at most one pending key per cycle, and only when the FIFO is not full, using round-robin order starting at rr_ptr.
REQ-019 SHALL, on a grant to key g, push g into the FIFO, clear pending[g], and set rr_ptr to (g+1) mod NUM_KEYS, all in the same cycle.
REQ-020 SHALL keep pending[g] set when a grant and a new press event for g occur in the same cycle (set wins).
REQ-021 SHALL compute FIFO full from registered occupancy, so a pop in the same cycle SHALL NOT enable a push while full.
REQ-022 SHALL define the registers as follows:
- address 0, read: stable levels in bits [NUM_KEYS-1:0].
- address 1, read: bit31 = FIFO not empty, bits[7:4] = occupancy, bits[1:0] = head key index; a read pops one entry when not empty.
- address 2, read/write: irq_mask in bit0.
- address 3, read: overflow[NUM_KEYS-1:0]; any write clears all overflow bits.
REQ-023 SHALL pop only on a cycle with chipselect=1, read_n=0, address=1 and FIFO not empty; reading an empty FIFO SHALL return bit31=0 and change no state.
REQ-024 SHALL update readdata one cycle after the read strobe (latency 1); unused bits SHALL read 0.
REQ-025 SHALL drive irq = irq_mask & FIFO not empty, combinationally from registered state.
REQ-026 SHALL let a simultaneous push and pop (not full) leave occupancy unchanged, with FIFO order preserved.

Reset
REQ-027 SHALL, on reset_n=0 at any time including mid-debounce or mid-transfer, immediately clear: synchronizers to 1, stable levels to all-ones, counters, pending, overflow, rr_ptr, FIFO pointers and occupancy, irq_mask, and readdata; irq SHALL be 0.
REQ-028 SHALL NOT generate a press event on the first cycles after reset release unless a key is held for DEBOUNCE_CYCLES.

Structure
REQ-029 SHALL place register address constants, the event-entry width and the readdata field positions in a shared package nios_ii_system_key_pkg.
REQ-030 SHALL implement synchronizer, debounce and fall detection in sub-module nios_ii_system_key_debouncer, instantiated NUM_KEYS times.

Verification (DEBOUNCE_CYCLES=8 for the bench)
REQ-031 Hold key1=0 for 7 cycles, then release -> no event; hold for 12 cycles -> exactly one FIFO entry with index 1, and irq=1 once irq_mask=1.
REQ-032 Press keys 0, 2 and 3 in the same cycle with rr_ptr=1 -> FIFO order 2, 3, 0; three reads at address 1 return 0x8000_0032, 0x8000_0023, 0x8000_0010.
REQ-033 Fill the FIFO to 4 entries, press key 0 twice -> pending[0]=1, overflow=0x1; a read pops one entry and the following cycle pushes key 0.
REQ-034 Read address 1 with the FIFO empty -> readdata=0 and occupancy unchanged; write address 3 -> overflow=0.
REQ-035 Assert reset_n=0 with 3 entries queued and a debounce half-complete -> all registers at reset values, irq=0, and no event after release.
